// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and the pixel type used by the read and write paths.
package vga_pkg;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FRAME_BYTES = H_ACTIVE * V_ACTIVE;
  localparam int AWIDTH      = 19;
  localparam int DWIDTH      = 8;

  typedef logic [DWIDTH-1:0] pixel_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy output and synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !flush && (level_q != LW'(DEPTH));
    do_pop   = pop && !flush && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign valid = (level_q != '0);
  assign head  = valid ? mem_q[rd_ptr_q] : '0;
  assign level = level_q;
endmodule

// File: rtl/pixel_prefetch.sv
// Credit-based scan-out prefetcher: issues sequential framebuffer reads and buffers returns in a FWFT FIFO.
// Define PIXEL_PREFETCH_UNDERRUN_EN for the sticky Underrun flag and the UnderrunCount output.
module pixel_prefetch #(
  parameter int AWIDTH       = vga_pkg::AWIDTH,
  parameter int DWIDTH       = vga_pkg::DWIDTH,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_BYTES  = vga_pkg::FRAME_BYTES,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          MemClk,
  input  logic                          MemRstN,
  input  logic                          FrameStart,
  input  logic [AWIDTH-1:0]             BaseAddr,
  output logic [AWIDTH-1:0]             ReqAddr,
  input  logic                          AddrTaken,
  input  logic [DWIDTH-1:0]             ReadData,
  input  logic                          ReadDataRdy,
  input  logic                          PixelPop,
  output logic [DWIDTH-1:0]             PixelData,
  output logic                          PixelValid,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
  output logic                          EndOfFrame,
`ifdef PIXEL_PREFETCH_UNDERRUN_EN
  output logic [15:0]                   UnderrunCount,
`endif
  output logic                          Underrun
);
  localparam int OW  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int QPW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW  = $clog2(MAX_INFLIGHT) + 1;

  logic [AWIDTH-1:0]       base_q, base_d;
  logic [OW-1:0]           offset_q, offset_d;
  logic [AWIDTH-1:0]       req_addr_q, req_addr_d;
  logic                    eof_q, eof_d;
  logic [MAX_INFLIGHT-1:0] keep_q, keep_d;
  logic [QPW-1:0]          iq_wr_q, iq_wr_d;
  logic [QPW-1:0]          iq_rd_q, iq_rd_d;
  logic [CW-1:0]           iq_cnt_q, iq_cnt_d;

  logic credit, advance, iq_push, iq_pop, fifo_push;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  // Credit reserves a FIFO slot for every outstanding read, kept or not.
  always_comb begin
    credit    = (int'(fifo_level) + int'(iq_cnt_q)) < FIFO_DEPTH;
    iq_pop    = ReadDataRdy && (iq_cnt_q != '0);
    iq_push   = AddrTaken && (iq_cnt_q != CW'(MAX_INFLIGHT));
    advance   = AddrTaken && credit && !FrameStart;
    fifo_push = iq_pop && keep_q[iq_rd_q] && !FrameStart;

    keep_d   = keep_q;
    iq_wr_d  = iq_wr_q;
    iq_rd_d  = iq_rd_q;
    iq_cnt_d = iq_cnt_q;
    if (iq_push) begin
      keep_d[iq_wr_q] = advance;
      iq_wr_d         = iq_wr_q + QPW'(1);
    end
    if (iq_pop) iq_rd_d = iq_rd_q + QPW'(1);
    case ({iq_push, iq_pop})
      2'b10:   iq_cnt_d = iq_cnt_q + CW'(1);
      2'b01:   iq_cnt_d = iq_cnt_q - CW'(1);
      default: iq_cnt_d = iq_cnt_q;
    endcase
    // Restart orphans every outstanding read while keeping the count so late returns drain harmlessly.
    if (FrameStart) keep_d = '0;

    base_d   = base_q;
    offset_d = offset_q;
    eof_d    = 1'b0;
    if (FrameStart) begin
      base_d   = BaseAddr;
      offset_d = '0;
    end else if (advance) begin
      if (offset_q == OW'(FRAME_BYTES - 1)) begin
        offset_d = '0;
        eof_d    = 1'b1;
      end else begin
        offset_d = offset_q + OW'(1);
      end
    end
    req_addr_d = base_d + AWIDTH'(offset_d);
  end

  always_ff @(posedge MemClk) begin
    if (!MemRstN) begin
      base_q     <= '0;
      offset_q   <= '0;
      req_addr_q <= '0;
      eof_q      <= 1'b0;
      keep_q     <= '0;
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
      iq_cnt_q   <= '0;
    end else begin
      base_q     <= base_d;
      offset_q   <= offset_d;
      req_addr_q <= req_addr_d;
      eof_q      <= eof_d;
      keep_q     <= keep_d;
      iq_wr_q    <= iq_wr_d;
      iq_rd_q    <= iq_rd_d;
      iq_cnt_q   <= iq_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk       (MemClk),
    .rst_n     (MemRstN),
    .flush     (FrameStart),
    .push      (fifo_push),
    .push_data (ReadData),
    .pop       (PixelPop),
    .head      (PixelData),
    .valid     (PixelValid),
    .level     (fifo_level)
  );

  assign ReqAddr    = req_addr_q;
  assign EndOfFrame = eof_q;
  assign FifoLevel  = fifo_level;

`ifdef PIXEL_PREFETCH_UNDERRUN_EN
  logic        underrun_q, underrun_d;
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    underrun_d = underrun_q;
    ucnt_d     = ucnt_q;
    if (FrameStart) begin
      underrun_d = 1'b0;
      ucnt_d     = '0;
    end else if (PixelPop && !PixelValid) begin
      underrun_d = 1'b1;
      if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge MemClk) begin
    if (!MemRstN) begin
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign Underrun      = underrun_q;
  assign UnderrunCount = ucnt_q;
`else
  assign Underrun = 1'b0;
`endif

  a_no_orphan_return: assert property (@(posedge MemClk) disable iff (!MemRstN)
    !(ReadDataRdy && (iq_cnt_q == '0)));
  a_no_inflight_overflow: assert property (@(posedge MemClk) disable iff (!MemRstN)
    !(AddrTaken && (iq_cnt_q == CW'(MAX_INFLIGHT))));
endmodule
